// File: rtl/hex_str_ser_pkg.sv
// hex_str_ser_pkg
//   Shared constants and types for the hex string serialiser:
//     - ASCII code points used to build the output characters
//     - FSM state encoding (IDLE / PFX0 / PFX1 / DIGIT)
//     - cnt_width(): width of the digit counter, never less than 1 bit
package hex_str_ser_pkg;

    localparam logic [7:0] ASC_0  = 8'h30;  // '0'
    localparam logic [7:0] ASC_LX = 8'h78;  // 'x'
    localparam logic [7:0] ASC_UA = 8'h41;  // 'A'
    localparam logic [7:0] ASC_LA = 8'h61;  // 'a'

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PFX0  = 2'd1,
        ST_PFX1  = 2'd2,
        ST_DIGIT = 2'd3
    } state_t;

    // A single-digit word still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/hex_str_ser_nib2asc.sv
// hex_nib2asc
//   Combinational nibble to ASCII hex digit converter.
//   Ports:
//     nib   in  4  value 0..15
//     lower in  1  1 = 'a'..'f' for 10..15, 0 = 'A'..'F'
//     asc   out 8  ASCII character
module hex_nib2asc
    import hex_str_ser_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       lower,
    output logic [7:0] asc
);

    always_comb begin
        asc = ASC_0;
        if (nib < 4'd10) begin
            asc = ASC_0 + {4'h0, nib};
        end else begin
            asc = (lower ? ASC_LA : ASC_UA) + {4'h0, nib} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_str_ser.sv
// hex_str_ser
//   Accepts one WIDTH-bit word and streams its hexadecimal text MSB-first,
//   one ASCII character per valid/ready handshake. Optional "0x" prefix,
//   lowercase digits, and per-word leading-zero suppression.
//   Parameters:
//     WIDTH  word width, multiple of 4 and >= 4
//     PREFIX 1 = emit "0x" before the digits
//     LOWER  1 = lowercase a-f
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     din, din_valid    word input; lz_sup sampled together with din
//     din_ready         idle and able to accept a word
//     dout, dout_valid  character output, held stable while stalled
//     dout_ready        consumer takes dout this cycle
//     dout_last         dout is the final character of the word
//     busy              conversion in progress
//   All outputs decode registered state only; no comb path from the inputs.
module hex_str_ser
    import hex_str_ser_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int PREFIX = 0,
    parameter int LOWER  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             lz_sup,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             busy
);

    localparam int NDIG = WIDTH / 4;
    localparam int CW   = cnt_width(NDIG);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lz_q, lz_d;

    logic [3:0] nib;
    logic [7:0] nib_asc;
    logic       cnt_zero;
    logic       skip;
    logic       accept;
    logic       xfer;

    assign nib      = sr_q[WIDTH-1 -: 4];
    assign cnt_zero = (cnt_q == '0);
    // A suppressed leading zero: consumes one cycle, produces no character.
    // The final digit is never skipped so an all-zero word still prints "0".
    assign skip     = (state_q == ST_DIGIT) && lz_q && (nib == 4'h0) && !cnt_zero;
    assign accept   = din_valid && din_ready;
    assign xfer     = dout_valid && dout_ready;

    hex_nib2asc u_nib2asc (
        .nib   (nib),
        .lower (LOWER != 0),
        .asc   (nib_asc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            lz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            lz_q    <= lz_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        lz_d    = lz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sr_d    = din;
                    lz_d    = lz_sup;
                    cnt_d   = CW'(NDIG - 1);
                    state_d = (PREFIX != 0) ? ST_PFX0 : ST_DIGIT;
                end
            end
            ST_PFX0: begin
                if (xfer) state_d = ST_PFX1;
            end
            ST_PFX1: begin
                if (xfer) state_d = ST_DIGIT;
            end
            ST_DIGIT: begin
                if (skip) begin
                    sr_d  = sr_q << 4;
                    cnt_d = cnt_q - CW'(1);
                end else if (xfer) begin
                    // Once a digit has been emitted later zeros are significant.
                    lz_d = 1'b0;
                    if (cnt_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        sr_d  = sr_q << 4;
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        din_ready  = 1'b0;
        dout       = 8'h00;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        busy       = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                din_ready = 1'b1;
            end
            ST_PFX0: begin
                dout       = ASC_0;
                dout_valid = 1'b1;
            end
            ST_PFX1: begin
                dout       = ASC_LX;
                dout_valid = 1'b1;
            end
            ST_DIGIT: begin
                dout_last = cnt_zero;
                if (!skip) begin
                    dout       = nib_asc;
                    dout_valid = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hex_str_ser.sv
// tb_hex_str_ser
//   Three instances: A (16-bit, plain), B (16-bit, "0x" prefix, lowercase)
//   sharing stimulus, and C (4-bit). Expected character strings come from a
//   digit-by-digit text model of the word.
module tb_hex_str_ser;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic        din_valid;
    logic        lz_sup;
    logic        dout_ready;

    logic       din_ready_a, dout_valid_a, dout_last_a, busy_a;
    logic [7:0] dout_a;
    logic       din_ready_b, dout_valid_b, dout_last_b, busy_b;
    logic [7:0] dout_b;

    logic [3:0] din_c;
    logic       din_valid_c, lz_c, dout_ready_c;
    logic       din_ready_c, dout_valid_c, dout_last_c, busy_c;
    logic [7:0] dout_c;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    hex_str_ser #(.WIDTH(16), .PREFIX(0), .LOWER(0)) dut_a (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_a), .lz_sup(lz_sup), .dout(dout_a),
        .dout_valid(dout_valid_a), .dout_ready(dout_ready),
        .dout_last(dout_last_a), .busy(busy_a)
    );

    hex_str_ser #(.WIDTH(16), .PREFIX(1), .LOWER(1)) dut_b (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_b), .lz_sup(lz_sup), .dout(dout_b),
        .dout_valid(dout_valid_b), .dout_ready(dout_ready),
        .dout_last(dout_last_b), .busy(busy_b)
    );

    hex_str_ser #(.WIDTH(4), .PREFIX(0), .LOWER(0)) dut_c (
        .clk(clk), .reset(reset), .din(din_c), .din_valid(din_valid_c),
        .din_ready(din_ready_c), .lz_sup(lz_c), .dout(dout_c),
        .dout_valid(dout_valid_c), .dout_ready(dout_ready_c),
        .dout_last(dout_last_c), .busy(busy_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Text model: the word's hex digits, leading zeros dropped (keeping at
    // least one digit) when lz is set, optional "0x" in front.
    task automatic model(input logic [15:0] v, input int width, input bit lz,
                         input bit pfx, input bit lower,
                         output logic [7:0] e[8], output int n, output int skips);
        int nd;
        int d[4];
        int first;
        nd = width / 4;
        n  = 0;
        for (int i = 0; i < 8; i++) e[i] = 8'h00;
        for (int i = 0; i < 4; i++) d[i] = 0;
        for (int i = 0; i < nd; i++) d[i] = int'((v >> (4 * (nd - 1 - i))) & 16'hF);
        first = 0;
        if (lz) while (first < nd - 1 && d[first] == 0) first++;
        skips = first;
        if (pfx) begin
            e[n] = 8'h30; n++;
            e[n] = 8'h78; n++;
        end
        for (int i = first; i < nd; i++) begin
            if (d[i] < 10) e[n] = 8'(48 + d[i]);
            else           e[n] = 8'((lower ? 97 : 65) + d[i] - 10);
            n++;
        end
    endtask

    // Converts one word on A and B together. mode 0: ready always 1,
    // mode 1: random ready, mode 2: ready low for the first 5 cycles.
    task automatic run_word(input logic [15:0] w, input bit lz, input int mode);
        logic [7:0] ea[8], eb[8];
        int na, nb, sa, sb, ia, ib, bub_a, bub_b, cyc;
        bit ha, hb, ra, rb;
        logic [7:0] hva, hvb;
        logic hla, hlb;
        model(w, 16, lz, 1'b0, 1'b0, ea, na, sa);
        model(w, 16, lz, 1'b1, 1'b1, eb, nb, sb);
        ia = 0; ib = 0; bub_a = 0; bub_b = 0; cyc = 0;
        ha = 0; hb = 0; ra = 0; rb = 0; hva = 0; hvb = 0; hla = 0; hlb = 0;
        @(negedge clk);
        chk("idle_rdy_a", din_ready_a, 1'b1);
        chk("idle_rdy_b", din_ready_b, 1'b1);
        din = w; lz_sup = lz; din_valid = 1'b1; dout_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = ($urandom_range(3) != 0);
                default: dout_ready = (cyc >= 5);
            endcase
            // instance A
            if (ha) begin
                chk("hold_dout_a", dout_a, hva);
                chk("hold_valid_a", dout_valid_a, 1'b1);
                chk("hold_last_a", dout_last_a, hla);
                ha = 0;
            end
            if (ra) begin
                chk("rdy_after_last_a", din_ready_a, 1'b1);
                ra = 0;
            end
            if (ia < na) begin
                chk("busy_rdy_a", din_ready_a, 1'b0);
                if (!dout_valid_a) bub_a++;
                else if (dout_ready) begin
                    chk($sformatf("char_a[%0d]", ia), dout_a, ea[ia]);
                    chk($sformatf("last_a[%0d]", ia), dout_last_a, (ia == na - 1));
                    ia++;
                    if (ia == na) ra = 1;
                end else begin
                    ha = 1; hva = dout_a; hla = dout_last_a;
                end
            end
            // instance B
            if (hb) begin
                chk("hold_dout_b", dout_b, hvb);
                chk("hold_valid_b", dout_valid_b, 1'b1);
                chk("hold_last_b", dout_last_b, hlb);
                hb = 0;
            end
            if (rb) begin
                chk("rdy_after_last_b", din_ready_b, 1'b1);
                rb = 0;
            end
            if (ib < nb) begin
                chk("busy_rdy_b", din_ready_b, 1'b0);
                if (!dout_valid_b) bub_b++;
                else if (dout_ready) begin
                    chk($sformatf("char_b[%0d]", ib), dout_b, eb[ib]);
                    chk($sformatf("last_b[%0d]", ib), dout_last_b, (ib == nb - 1));
                    ib++;
                    if (ib == nb) rb = 1;
                end else begin
                    hb = 1; hvb = dout_b; hlb = dout_last_b;
                end
            end
            // Junk on the input side while both are busy must be ignored.
            din = 16'($urandom);
            lz_sup = 1'($urandom);
            din_valid = (ia < na && ib < nb) ? 1'($urandom) : 1'b0;
            cyc++;
            if (ia == na && ib == nb && !ra && !rb) break;
            if (cyc > 200) break;
        end
        din_valid = 1'b0;
        chk("chars_a", ia, na);
        chk("chars_b", ib, nb);
        chk("bubbles_a", bub_a, sa);
        chk("bubbles_b", bub_b, sb);
        $display("word %h lz=%0d mode=%0d: A %0d chars, B %0d chars, %0d cycles",
                 w, lz, mode, ia, ib, cyc);
    endtask

    // Called at a negedge where C must be idle; returns one negedge after the
    // single transfer, so consecutive calls are back-to-back words.
    task automatic run_c(input logic [3:0] v, input bit lz);
        logic [7:0] e[8];
        int n, s;
        model({12'h000, v}, 4, lz, 1'b0, 1'b0, e, n, s);
        chk("c_idle_rdy", din_ready_c, 1'b1);
        chk("c_idle_valid", dout_valid_c, 1'b0);
        din_c = v; lz_c = lz; din_valid_c = 1'b1;
        @(negedge clk);
        din_valid_c = 1'b0;
        chk("c_valid", dout_valid_c, 1'b1);
        chk("c_char", dout_c, e[0]);
        chk("c_last", dout_last_c, 1'b1);
        chk("c_busy_rdy", din_ready_c, 1'b0);
        @(negedge clk);
        $display("C word %h lz=%0d: char %h", v, lz, e[0]);
    endtask

    initial begin
        reset = 1'b1;
        din = 16'h0; din_valid = 1'b0; lz_sup = 1'b0; dout_ready = 1'b1;
        din_c = 4'h0; din_valid_c = 1'b0; lz_c = 1'b0; dout_ready_c = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rdy_a", din_ready_a, 1'b1);
        chk("rst_valid_a", dout_valid_a, 1'b0);
        chk("rst_last_a", dout_last_a, 1'b0);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_dout_a", dout_a, 8'h00);
        chk("rst_valid_b", dout_valid_b, 1'b0);
        chk("rst_valid_c", dout_valid_c, 1'b0);
        reset = 1'b0;

        // Directed words
        run_word(16'h1A2F, 1'b0, 0);
        run_word(16'h00BE, 1'b1, 0);
        run_word(16'h0000, 1'b1, 0);
        run_word(16'hC0DE, 1'b0, 2);
        run_word(16'h0F00, 1'b1, 1);

        // Reset mid-word
        @(negedge clk);
        din = 16'hFFFF; lz_sup = 1'b0; din_valid = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_rdy_a", din_ready_a, 1'b1);
        chk("abort_valid_a", dout_valid_a, 1'b0);
        chk("abort_busy_a", busy_a, 1'b0);
        chk("abort_last_a", dout_last_a, 1'b0);
        chk("abort_rdy_b", din_ready_b, 1'b1);
        chk("abort_valid_b", dout_valid_b, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_quiet_a", dout_valid_a, 1'b0);
            chk("abort_quiet_b", dout_valid_b, 1'b0);
        end
        run_word(16'h0001, 1'b0, 0);
        run_word(16'h0001, 1'b1, 0);

        // Random words
        for (int k = 0; k < 20; k++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (k % 4 == 0) w = w & 16'h00FF;
            run_word(w, 1'($urandom), 1);
        end

        // 4-bit instance, back-to-back words
        @(negedge clk);
        run_c(4'h9, 1'b0);
        run_c(4'h0, 1'b1);
        run_c(4'hA, 1'b1);
        for (int k = 0; k < 6; k++) run_c(4'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
